truth_table_sweep_ctrl: RTL and testbench

//   Sequencer that exhaustively exercises one 3-input combinational gate block (e.g. m0xC2).
//   On start it drives all 8 input combinations, waits a settle interval, and samples the gate output.
//   It assembles the 8-bit truth-table byte, compares it with the expected function code,
//   and reports pass/fail and the failing rows.

---
 rtl/truth_table_sweep_ctrl.sv | 152 +++++++++++++++
 tb/tb_truth_table_sweep_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep_ctrl.sv
// Truth-table sweep controller: drives all eight input rows of a 3-input gate,
// waits a settle interval per row, samples the gate output and compares the
// assembled byte against the expected function code.
module truth_table_sweep_ctrl #(
  parameter logic [7:0]  EXPECTED      = 8'hC2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] captured,
  output logic       pass,
  output logic [7:0] mismatch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       ins_q, ins_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       captured_q, captured_d;
  logic             pass_q, pass_d;
  logic [7:0]       mismatch_q, mismatch_d;

  // Next-state and next-output logic; gate inputs are loaded on entry to APPLY
  // so they are already stable during APPLY, WAIT and SAMPLE of each row.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ins_d      = ins_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    captured_d = captured_q;
    pass_d     = pass_q;
    mismatch_d = mismatch_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_APPLY;
          idx_d      = 3'd0;
          ins_d      = 3'd0;
          busy_d     = 1'b1;
          captured_d = 8'h00;
          pass_d     = 1'b0;
          mismatch_d = 8'h00;
        end
      end
      S_APPLY: begin
        cnt_d   = SETTLE;
        state_d = (SETTLE_CYCLES > 0) ? S_WAIT : S_SAMPLE;
      end
      S_WAIT: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        captured_d[3'd7 - idx_q] = gate_out;
        if (idx_q == 3'd7) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_d     = (captured_d == EXPECTED);
          mismatch_d = captured_d ^ EXPECTED;
        end else begin
          idx_d   = idx_q + 3'd1;
          ins_d   = idx_q + 3'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ins_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        ins_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort cancels an active sweep outright: no sample is taken in the abort
    // cycle, the partial capture is kept, and the verdict is cleared.
    if (abort && (state_q == S_APPLY || state_q == S_WAIT || state_q == S_SAMPLE)) begin
      state_d    = S_IDLE;
      ins_d      = 3'd0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      captured_d = captured_q;
      pass_d     = 1'b0;
      mismatch_d = 8'h00;
    end
  end

  // State and registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      ins_q      <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      captured_q <= 8'h00;
      pass_q     <= 1'b0;
      mismatch_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ins_q      <= ins_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      captured_q <= captured_d;
      pass_q     <= pass_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign in1      = ins_q[2];
  assign in2      = ins_q[1];
  assign in3      = ins_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign captured = captured_q;
  assign pass     = pass_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
// Bench for truth_table_sweep_ctrl: two instances (settle 4 and settle 0)
// driven by bench-side gate stubs and checked every cycle against a
// row/phase arithmetic model, plus directed literal expectations.
module tb_truth_table_sweep_ctrl;

  localparam logic [7:0] EXP = 8'hC2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start_w [2];
  logic       abort_w [2];
  logic       gate_w  [2];
  logic       in1_w   [2];
  logic       in2_w   [2];
  logic       in3_w   [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic [7:0] cap_w   [2];
  logic [7:0] mis_w   [2];

  int         mode [2];   // 0 ideal, 1 stuck0, 2 stuck1, 3 ideal delayed 3 cycles
  logic [2:0] dly  [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  truth_table_sweep_ctrl #(.EXPECTED(EXP), .SETTLE_CYCLES(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_w[0]), .abort(abort_w[0]), .gate_out(gate_w[0]),
    .in1(in1_w[0]), .in2(in2_w[0]), .in3(in3_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .captured(cap_w[0]), .pass(pass_w[0]), .mismatch(mis_w[0]));

  truth_table_sweep_ctrl #(.EXPECTED(EXP), .SETTLE_CYCLES(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_w[1]), .abort(abort_w[1]), .gate_out(gate_w[1]),
    .in1(in1_w[1]), .in2(in2_w[1]), .in3(in3_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .captured(cap_w[1]), .pass(pass_w[1]), .mismatch(mis_w[1]));

  function automatic int settle(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic logic ideal(input logic [2:0] r);
    logic [7:0] e;
    e = EXP;
    return e[3'd7 - r];
  endfunction

  function automatic logic [2:0] ins_of(input int i);
    return {in1_w[i], in2_w[i], in3_w[i]};
  endfunction

  // Gate stubs.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      case (mode[i])
        0:       gate_w[i] = ideal(ins_of(i));
        1:       gate_w[i] = 1'b0;
        2:       gate_w[i] = 1'b1;
        default: gate_w[i] = dly[i][2];
      endcase
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) dly[i] <= {dly[i][1:0], ideal(ins_of(i))};
  end

  task automatic chk(input string nm, input int i, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %0h, expected %0h at %0t", nm, i, a, e, $time);
    end
  endtask

  // Behavioural model: a sweep is a cycle counter t (1..8*(S+2)); row and
  // phase follow by division, the sample happens at the last phase of a row.
  int         m_act  [2];
  int         m_t    [2];
  logic [7:0] m_cap  [2];
  logic [7:0] m_mis  [2];
  logic       m_pass [2];
  logic       m_done [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_t[i] = 0; m_cap[i] = 8'h00; m_mis[i] = 8'h00;
        m_pass[i] = 1'b0; m_done[i] = 1'b0;
      end else begin
        automatic logic prevd = m_done[i];
        automatic int   len   = settle(i) + 2;
        m_done[i] = 1'b0;
        if (m_act[i] != 0) begin
          if (abort_w[i]) begin
            m_act[i] = 0; m_pass[i] = 1'b0; m_mis[i] = 8'h00;
          end else begin
            if ((m_t[i] - 1) % len == len - 1)
              m_cap[i][7 - (m_t[i] - 1) / len] = gate_w[i];
            if (m_t[i] == 8 * len) begin
              m_act[i]  = 0;
              m_done[i] = 1'b1;
              m_pass[i] = (m_cap[i] == EXP);
              m_mis[i]  = m_cap[i] ^ EXP;
            end else begin
              m_t[i]++;
            end
          end
        end else if (!prevd && start_w[i] && !abort_w[i]) begin
          m_act[i] = 1; m_t[i] = 1; m_cap[i] = 8'h00; m_pass[i] = 1'b0; m_mis[i] = 8'h00;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, int'(busy_w[i]), int'(m_act[i] != 0));
        chk("done", i, int'(done_w[i]), int'(m_done[i]));
        chk("captured", i, int'(cap_w[i]), int'(m_cap[i]));
        chk("pass", i, int'(pass_w[i]), int'(m_pass[i]));
        chk("mismatch", i, int'(mis_w[i]), int'(m_mis[i]));
        if (!m_done[i])
          chk("ins", i, int'(ins_of(i)),
              (m_act[i] != 0) ? (m_t[i] - 1) / (settle(i) + 2) : 0);
      end
    end
  end

  // Leaves the caller at the falling edge inside cycle 1.
  task automatic pulse_start(input int i);
    @(negedge clk);
    start_w[i] = 1'b1;
    @(negedge clk);
    start_w[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int cyc);
    cyc = 1;
    while (!done_w[i] && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    chk({tag, "_busy"}, i, int'(busy_w[i]), 0);
    chk({tag, "_done"}, i, int'(done_w[i]), 0);
    chk({tag, "_ins"}, i, int'(ins_of(i)), 0);
    chk({tag, "_cap"}, i, int'(cap_w[i]), 0);
    chk({tag, "_pass"}, i, int'(pass_w[i]), 0);
    chk({tag, "_mis"}, i, int'(mis_w[i]), 0);
  endtask

  initial begin
    int c;
    int ndone;
    for (int i = 0; i < 2; i++) begin
      start_w[i] = 1'b0; abort_w[i] = 1'b0; mode[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "rst");
    check_reset_vals(1, "rst");
    #2 rst = 1'b0;
    chk_en = 1'b1;

    // Ideal gate, settle 4.
    pulse_start(0);
    wait_done(0, 200, c);
    chk("done_cycle_s4", 0, c, 49);
    chk("ideal_cap", 0, int'(cap_w[0]), 'hC2);
    chk("ideal_pass", 0, int'(pass_w[0]), 1);
    chk("ideal_mis", 0, int'(mis_w[0]), 0);
    repeat (3) @(negedge clk);
    chk("hold_cap", 0, int'(cap_w[0]), 'hC2);

    // Stuck-at gates.
    mode[0] = 1;
    pulse_start(0);
    wait_done(0, 200, c);
    chk("s0_cap", 0, int'(cap_w[0]), 'h00);
    chk("s0_pass", 0, int'(pass_w[0]), 0);
    chk("s0_mis", 0, int'(mis_w[0]), 'hC2);
    mode[0] = 2;
    pulse_start(0);
    wait_done(0, 200, c);
    chk("s1_cap", 0, int'(cap_w[0]), 'hFF);
    chk("s1_pass", 0, int'(pass_w[0]), 0);
    chk("s1_mis", 0, int'(mis_w[0]), 'h3D);

    // Delayed gate: enough settle passes, zero settle fails.
    mode[0] = 3;
    pulse_start(0);
    wait_done(0, 200, c);
    chk("dly_s4_pass", 0, int'(pass_w[0]), 1);
    chk("dly_s4_cap", 0, int'(cap_w[0]), 'hC2);
    mode[1] = 3;
    pulse_start(1);
    wait_done(1, 200, c);
    chk("dly_s0_pass", 1, int'(pass_w[1]), 0);
    chk("dly_s0_cap_differs", 1, int'(cap_w[1] != 8'hC2), 1);

    // Zero settle: input sequence, second start ignored, done at 17.
    mode[1] = 0;
    mode[0] = 0;
    repeat (2) @(negedge clk);
    pulse_start(1);
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) chk("seq_ins", 1, int'(ins_of(1)), (k - 1) / 2);
      else         chk("done_cycle_s0", 1, int'(done_w[1]), 1);
      start_w[1] = (k == 5);
      @(negedge clk);
    end
    start_w[1] = 1'b0;
    chk("s0_pass_final", 1, int'(pass_w[1]), 1);

    // Abort in cycle 20, then a clean sweep.
    repeat (2) @(negedge clk);
    pulse_start(0);
    repeat (19) @(negedge clk);
    abort_w[0] = 1'b1;
    @(negedge clk);
    abort_w[0] = 1'b0;
    chk("abort_busy", 0, int'(busy_w[0]), 0);
    chk("abort_ins", 0, int'(ins_of(0)), 0);
    chk("abort_pass", 0, int'(pass_w[0]), 0);
    chk("abort_partial_cap", 0, int'(cap_w[0]), 'hC0);
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_w[0]) ndone++;
    end
    chk("abort_no_done", 0, ndone, 0);
    pulse_start(0);
    wait_done(0, 200, c);
    chk("after_abort_cycle", 0, c, 49);
    chk("after_abort_pass", 0, int'(pass_w[0]), 1);

    // Asynchronous reset in the middle of a WAIT.
    repeat (2) @(negedge clk);
    pulse_start(0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals(0, "async_rst");
    @(negedge clk);
    #2 rst = 1'b0;
    pulse_start(0);
    wait_done(0, 200, c);
    chk("after_rst_cycle", 0, c, 49);
    chk("after_rst_pass", 0, int'(pass_w[0]), 1);

    // Randomized traffic on both instances.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (k % 250 == 0) begin
        mode[0] = int'($urandom_range(0, 3));
        mode[1] = int'($urandom_range(0, 3));
      end
      for (int i = 0; i < 2; i++) begin
        start_w[i] = ($urandom_range(0, 7) == 0);
        abort_w[i] = ($urandom_range(0, 79) == 0);
      end
    end
    for (int i = 0; i < 2; i++) begin
      start_w[i] = 1'b0; abort_w[i] = 1'b0;
    end
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
